fir_requant: RTL and testbench

FIR_REQUANT -- requirements
Module: fir_requant

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_requant_if.sv | 29 ++
 rtl/fir_sfifo.sv | 74 +++++++
 rtl/fir_requant.sv | 79 +++++++
 tb/tb_fir_requant.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared constants and types for the FIR requantizer slice.
//   IN_W / OUT_W : sample widths before and after requantization
//   COEF_SUM     : sum of the FIR taps (34+94+94+34); its log2 is the default
//                  right shift that restores unity gain
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int unsigned IN_W      = 16;
    localparam int unsigned OUT_W     = 8;
    localparam int unsigned COEF_SUM  = 256;
    localparam int unsigned SHIFT_DEF = $clog2(COEF_SUM);

    typedef logic [IN_W-1:0]  in_t;
    typedef logic [OUT_W-1:0] out_t;

    // Largest storable output, and the value upstream uses to flag its own
    // saturation.
    localparam out_t OUT_MAX     = '1;
    localparam in_t  IN_SAT_MARK = '1;

endpackage

// File: rtl/fir_requant_if.sv
// -----------------------------------------------------------------------------
// fir_requant_if
// Bundles both valid/ready streams of the requantizer.
//   in_data/in_valid/in_ready    : 16-bit filter samples in
//   out_data/out_valid/out_ready : 8-bit requantized samples out
// master = the environment (upstream source + downstream sink)
// slave  = the requantizer
// -----------------------------------------------------------------------------
interface fir_requant_if;
    import fir_pkg::*;

    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/fir_sfifo.sv
// -----------------------------------------------------------------------------
// fir_sfifo
// Synchronous FIFO, WIDTH bits x DEPTH entries (DEPTH a power of two >= 2).
//   clk, rst_n : clock, asynchronous active-low reset
//   i_flush    : synchronous clear; overrides a concurrent push/pop
//   i_push     : write i_wdata at the tail (ignored when full)
//   i_pop      : retire the head entry (ignored when empty)
//   o_rdata    : head entry, zero while empty
//   o_full     : occupancy == DEPTH
//   o_empty    : occupancy == 0
// -----------------------------------------------------------------------------
module fir_sfifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Head is masked while empty so the output reads zero out of reset.
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fir_requant.sv
// -----------------------------------------------------------------------------
// fir_requant
// Rounds FIR output samples back to 8 bits (add half LSB, shift right by
// SHIFT, saturate at 255), buffers them in a DEPTH-entry FIFO and counts
// clipped samples.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous FIFO clear (clip count kept)
//   bus        : in_data/in_valid/in_ready and out_data/out_valid/out_ready
//   clip_cnt   : saturating count of pushed samples that clipped
// -----------------------------------------------------------------------------
module fir_requant
    import fir_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SHIFT = SHIFT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    fir_requant_if.slave     bus,
    output logic [OUT_W-1:0] clip_cnt
);

    localparam int unsigned SUM_W = IN_W + 1;
    typedef logic [SUM_W-1:0] sum_t;
    localparam sum_t ROUND = sum_t'(1) << (SHIFT - 1);

    sum_t       w_sum;
    sum_t       w_res;
    logic       w_over;
    logic       w_clip;
    out_t       w_q;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    out_t       r_clip_cnt;

    // One extra bit so the rounding add cannot overflow.
    assign w_sum  = {1'b0, bus.in_data} + ROUND;
    assign w_res  = w_sum >> SHIFT;
    assign w_over = (w_res > sum_t'(OUT_MAX));
    assign w_clip = w_over || (bus.in_data == IN_SAT_MARK);
    assign w_q    = w_over ? OUT_MAX : w_res[OUT_W-1:0];

    // Both handshake outputs come straight from FIFO occupancy state, so
    // there is no combinational path from out_ready to in_ready.
    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;
    assign w_push        = bus.in_valid && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;

    fir_sfifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_push  (w_push),
        .i_wdata (w_q),
        .i_pop   (w_pop),
        .o_rdata (bus.out_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A push discarded by flush never reaches the FIFO, so it is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clip_cnt <= '0;
        end else if (w_push && !flush && w_clip && (r_clip_cnt != OUT_MAX)) begin
            r_clip_cnt <= r_clip_cnt + 1'b1;
        end
    end

    assign clip_cnt = r_clip_cnt;

endmodule

// File: tb/tb_fir_requant.sv
// -----------------------------------------------------------------------------
// tb_fir_requant
// Scoreboard bench for fir_requant: accepted samples are converted by an
// arithmetic reference model and queued; a monitor on the falling edge checks
// handshake flags, head data and clip count against the queue.
// -----------------------------------------------------------------------------
module tb_fir_requant;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SHIFT = 8;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [7:0] clip_cnt;

    fir_requant_if bus();

    fir_requant #(
        .DEPTH (DEPTH),
        .SHIFT (SHIFT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus),
        .clip_cnt (clip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests  = 0;
    int unsigned n_fail   = 0;
    int unsigned push_cnt = 0;
    int unsigned m_clip   = 0;
    int unsigned q[$];

    function automatic void check(string name, int unsigned act, int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: round half up by plain integer division, then clamp.
    function automatic int unsigned model_val(int unsigned d);
        int unsigned r;
        r = (d + (1 << (SHIFT - 1))) / (1 << SHIFT);
        return (r > 255) ? 255 : r;
    endfunction

    function automatic bit model_clip(int unsigned d);
        return ((d + (1 << (SHIFT - 1))) / (1 << SHIFT) > 255) || (d == 65535);
    endfunction

    // Monitor / scoreboard: check current state, then apply this edge's events.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_clip = 0;
        end
        check("out_valid", bus.out_valid, (q.size() != 0) ? 1 : 0);
        check("in_ready", bus.in_ready, (q.size() < DEPTH) ? 1 : 0);
        check("clip_cnt", clip_cnt, m_clip);
        if (q.size() != 0) check("out_data", bus.out_data, q[0]);
        if (rst_n) begin
            if (flush) begin
                q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready && q.size() != 0) void'(q.pop_front());
                if (bus.in_valid && bus.in_ready) begin
                    q.push_back(model_val(bus.in_data));
                    if (model_clip(bus.in_data) && m_clip < 255) m_clip++;
                    push_cnt++;
                end
            end
        end
    end

    // Holds in_valid until the sample is taken; returns 1 ns after the push edge.
    task automatic send(input logic [15:0] d);
        bit ok;
        ok = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("send_accept", ok, 1);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (!bus.out_valid && q.size() == 0) ok = 1;
        end
        @(posedge clk);
        #1;
        check("drain_done", ok, 1);
    endtask

    task automatic send_kat(input logic [15:0] d, input int unsigned exp);
        send(d);
        check("kat_valid", bus.out_valid, 1);
        check("kat_data", bus.out_data, exp);
    endtask

    initial begin
        int unsigned w;
        int unsigned p0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        rst_n         = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_clip", clip_cnt, 0);
        check("rst_in_ready", bus.in_ready, 1);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Rounding boundaries, latency 1, no clipping.
        bus.out_ready = 1'b1;
        send_kat(16'h1280, 8'h13);
        send_kat(16'h127F, 8'h12);
        send_kat(16'h8000, 8'h80);
        drain();
        check("clip_after_kat", clip_cnt, 0);

        // Saturation and upstream marker both clip.
        send_kat(16'hFF80, 255);
        send_kat(16'hFFFF, 255);
        drain();
        check("clip_after_sat", clip_cnt, 2);

        // Unity gain.
        send_kat(16'h6400, 100);
        drain();

        // Backpressure: fifth sample waits for the first pop.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'($urandom));
        check("full_in_ready", bus.in_ready, 0);
        bus.in_data   = 16'($urandom);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.in_ready && w < 20);
        check("fifth_wait", w, 2);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        drain();

        // Full FIFO streaming: first cycle pops only, then one in/one out.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'($urandom));
        p0 = push_cnt;
        bus.in_data   = 16'($urandom);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1 bus.in_data = 16'($urandom);
        end
        bus.in_valid = 1'b0;
        check("stream_pushes", push_cnt - p0, 7);
        drain();

        // Random traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 3))
                0: bus.in_data = 16'($urandom);
                1: bus.in_data = 16'hFFFF;
                2: bus.in_data = 16'($urandom_range(16'hFF00, 16'hFFFE));
                default: bus.in_data = 16'($urandom_range(0, 16'h03FF));
            endcase
            bus.in_valid  = 1'($urandom);
            bus.out_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        drain();

        // Clip counter saturation.
        for (int i = 0; i < 300; i++) send(16'hFFFF);
        check("clip_sat", clip_cnt, 255);
        drain();

        // Flush mid-stream.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(16'($urandom));
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_valid", bus.out_valid, 0);
        check("flush_ready", bus.in_ready, 1);
        check("flush_clip", clip_cnt, 255);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 2; i++) send(16'($urandom));
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", bus.out_valid, 0);
        check("arst_data", bus.out_data, 0);
        check("arst_clip", clip_cnt, 0);
        check("arst_ready", bus.in_ready, 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send_kat(16'h6400, 100);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
